map_view_ctrl: RTL

//  Frame-synchronous camera/view controller for the mode-7 ground-map renderer. Accepts ball

---
 rtl/map_view_pkg.sv | 19 +
 rtl/hold_repeat.sv | 27 ++
 rtl/map_view_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/map_view_pkg.sv
// Shared types and constants for the mode-7 view controller.
package map_view_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } view_state_t;

  localparam int ANGLE_FULL = 360;
  localparam int COORD_W    = 16;
  localparam int MAG_W      = 16;

  // Folds a heading in 0..719 back into 0..359.
  function automatic logic [COORD_W-1:0] wrap_angle(input logic [COORD_W-1:0] a);
    return (a >= COORD_W'(ANGLE_FULL)) ? a - COORD_W'(ANGLE_FULL) : a;
  endfunction

endpackage

// File: rtl/hold_repeat.sv
// Auto-repeat generator: pulses on the first held cycle, then every REPEAT_CYCLES while held.
module hold_repeat #(
  parameter int REPEAT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic step_out
);

  localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  assign step_out = btn_in && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst || !btn_in) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/map_view_ctrl.sv
// Frame-synchronous view controller: buffers game updates and button-driven plane magnitudes,
// publishing one coherent parameter set per frame.
module map_view_ctrl
  import map_view_pkg::*;
#(
  parameter int REPEAT_CYCLES = 100000,
  parameter int FAR_INIT      = 2,
  parameter int NEAR_INIT     = 0,
  parameter int MAG_MAX       = 255
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               new_frame_in,
  input  logic               upd_valid_in,
  output logic               upd_ready_out,
  input  logic [COORD_W-1:0] ballx_in,
  input  logic [COORD_W-1:0] bally_in,
  input  logic [COORD_W-1:0] angle_in,
  input  logic [3:0]         change_in,
  output logic [COORD_W-1:0] ballx_out,
  output logic [COORD_W-1:0] bally_out,
  output logic [COORD_W-1:0] angle_out,
  output logic [MAG_W-1:0]   far_mag_out,
  output logic [MAG_W-1:0]   near_mag_out,
  output logic               frame_commit_out,
  output logic               err_angle_out
);

  view_state_t        state;
  logic [COORD_W-1:0] shadow_x, shadow_y, shadow_a;
  logic [MAG_W-1:0]   far_w, near_w, far_nx, near_nx;
  logic               far_step, near_step;
  logic               transfer, angle_ok;

  assign upd_ready_out = !rst_in && (state != COMMIT);
  assign transfer      = upd_valid_in && upd_ready_out;
  assign angle_ok      = angle_in < COORD_W'(2 * ANGLE_FULL);

  // One repeat counter per pair; the pair is "held" if either direction is pressed.
  hold_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_far_rep (
    .clk     (pixel_clk_in),
    .rst     (rst_in),
    .btn_in  (change_in[0] | change_in[1]),
    .step_out(far_step)
  );

  hold_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_near_rep (
    .clk     (pixel_clk_in),
    .rst     (rst_in),
    .btn_in  (change_in[2] | change_in[3]),
    .step_out(near_step)
  );

  // Near is bounded by the post-step far value so near <= far is never violated.
  always_comb begin
    far_nx  = far_w;
    near_nx = near_w;
    if (far_step) begin
      if (change_in[0]) begin
        if (far_w < MAG_W'(MAG_MAX)) far_nx = far_w + 1'b1;
      end else if (far_w > near_w) begin
        far_nx = far_w - 1'b1;
      end
    end
    if (near_step) begin
      if (change_in[2]) begin
        if (near_w < far_nx) near_nx = near_w + 1'b1;
      end else if (near_w != '0) begin
        near_nx = near_w - 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      shadow_x         <= '0;
      shadow_y         <= '0;
      shadow_a         <= '0;
      far_w            <= MAG_W'(FAR_INIT);
      near_w           <= MAG_W'(NEAR_INIT);
      ballx_out        <= '0;
      bally_out        <= '0;
      angle_out        <= '0;
      far_mag_out      <= MAG_W'(FAR_INIT);
      near_mag_out     <= MAG_W'(NEAR_INIT);
      frame_commit_out <= 1'b0;
      err_angle_out    <= 1'b0;
    end else begin
      far_w            <= far_nx;
      near_w           <= near_nx;
      frame_commit_out <= 1'b0;

      // Out-of-range headings complete the handshake but never reach the shadow.
      if (transfer && angle_ok) begin
        shadow_x <= ballx_in;
        shadow_y <= bally_in;
        shadow_a <= wrap_angle(angle_in);
      end
      if (transfer && !angle_ok) err_angle_out <= 1'b1;

      case (state)
        IDLE: begin
          if (new_frame_in)            state <= COMMIT;
          else if (transfer && angle_ok) state <= PENDING;
        end
        PENDING: begin
          if (new_frame_in) state <= COMMIT;
        end
        COMMIT: begin
          ballx_out        <= shadow_x;
          bally_out        <= shadow_y;
          angle_out        <= shadow_a;
          far_mag_out      <= far_w;
          near_mag_out     <= near_w;
          frame_commit_out <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
